// File: rtl/uart_pkg.sv
// ============================================================================
// Module      : uart_pkg
// Description : Shared types and constants for the UART receive path.
//               Optional build macro used by uart_rx_core: RX_MAJORITY_VOTE_EN
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package uart_pkg;

  // Data bits per 8N1 frame
  localparam int UART_DATA_BITS = 8;

  // Clock cycles per bit for a 50 MHz clock at 115200 baud
  localparam int UART_BAUD_DIV_DEFAULT = 434;

  // Receive state machine encoding
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    ERR   = 3'd4
  } uart_rx_state_e;

endpackage : uart_pkg

`default_nettype wire

// File: rtl/uart_rx_sync.sv
// ============================================================================
// Module      : uart_rx_sync
// Description : Multi-stage synchroniser for the asynchronous rx pin. All
//               stages reset to 1 so an idle line never looks like a start.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module uart_rx_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic rx,
  output logic rxs
);

  logic [SYNC_STAGES-1:0] r_sync;

  // Shift the raw pin through the synchroniser chain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], rx};
    end
  end

  assign rxs = r_sync[SYNC_STAGES-1];

endmodule : uart_rx_sync

`default_nettype wire

// File: rtl/uart_rx_core.sv
// ============================================================================
// Module      : uart_rx_core
// Description : 8N1 UART receive engine. Deserialises rx (LSB first) into
//               rx_data with a one-cycle done pulse, reports busy / framing
//               error, and holds a level irq until rx_finish.
//               Build macro RX_MAJORITY_VOTE_EN: when defined, each sample
//               point uses a 2-of-3 vote over mid-bit-1, mid-bit, mid-bit+1.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module uart_rx_core
  import uart_pkg::*;
#(
  parameter int BAUD_DIV    = UART_BAUD_DIV_DEFAULT,
  parameter int SYNC_STAGES = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      rx,
  input  logic                      rx_finish,
  output logic [UART_DATA_BITS-1:0] rx_data,
  output logic                      done,
  output logic                      rx_busy,
  output logic                      frame_err,
  output logic                      irq
);

  localparam logic [15:0] c_bit_last = 16'(BAUD_DIV - 1);
  localparam logic [2:0]  c_idx_last = 3'(UART_DATA_BITS - 1);
`ifdef RX_MAJORITY_VOTE_EN
  // Decision is taken one cycle after mid-bit, once the third vote is in;
  // every later sample point inherits that one-cycle shift.
  localparam logic [15:0] c_start_pt = 16'(BAUD_DIV / 2);
`else
  localparam logic [15:0] c_start_pt = 16'(BAUD_DIV / 2 - 1);
`endif

  logic                      w_rxs;
  logic                      w_bit;
  uart_rx_state_e            r_state, w_state_nx;
  logic [15:0]               r_baud_cnt, w_cnt_nx;
  logic [2:0]                r_bit_idx, w_idx_nx;
  logic [UART_DATA_BITS-1:0] r_shift, w_shift_nx;
  logic                      w_done_nx;
  logic                      r_done, r_busy, r_frame_err, r_irq;
  logic [UART_DATA_BITS-1:0] r_rx_data;

  uart_rx_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .rx    (rx),
    .rxs   (w_rxs)
  );

`ifdef RX_MAJORITY_VOTE_EN
  logic [1:0] r_hist;

  // Keep the two previous synchronised samples for the 2-of-3 vote
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hist <= 2'b11;
    end else begin
      r_hist <= {r_hist[0], w_rxs};
    end
  end

  assign w_bit = (r_hist[1] & r_hist[0]) | (r_hist[1] & w_rxs) | (r_hist[0] & w_rxs);
`else
  assign w_bit = w_rxs;
`endif

  // Next-state, counter, shift-register and done decode
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_baud_cnt + 16'd1;
    w_idx_nx   = r_bit_idx;
    w_shift_nx = r_shift;
    w_done_nx  = 1'b0;
    case (r_state)
      IDLE: begin
        // IDLE is only ever entered with rxs high, so a low level is a start edge
        w_cnt_nx = '0;
        if (!w_rxs) w_state_nx = START;
      end
      START: begin
        if (r_baud_cnt == c_start_pt) begin
          w_cnt_nx   = '0;
          w_idx_nx   = '0;
          w_state_nx = w_bit ? IDLE : DATA;
        end
      end
      DATA: begin
        if (r_baud_cnt == c_bit_last) begin
          w_cnt_nx              = '0;
          w_shift_nx[r_bit_idx] = w_bit;
          w_idx_nx              = r_bit_idx + 3'd1;
          if (r_bit_idx == c_idx_last) w_state_nx = STOP;
        end
      end
      STOP: begin
        if (r_baud_cnt == c_bit_last) begin
          w_cnt_nx = '0;
          if (w_bit) begin
            w_done_nx  = 1'b1;
            w_state_nx = IDLE;
          end else begin
            w_state_nx = ERR;
          end
        end
      end
      ERR: begin
        // Wait for a full bit time of continuous idle before re-arming
        if (!w_rxs) begin
          w_cnt_nx = '0;
        end else if (r_baud_cnt == c_bit_last) begin
          w_cnt_nx   = '0;
          w_state_nx = IDLE;
        end
      end
      default: begin
        w_cnt_nx   = '0;
        w_state_nx = IDLE;
      end
    endcase
  end

  // State, counters, shift register and registered status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_baud_cnt  <= '0;
      r_bit_idx   <= '0;
      r_shift     <= '0;
      r_done      <= 1'b0;
      r_busy      <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_baud_cnt  <= w_cnt_nx;
      r_bit_idx   <= w_idx_nx;
      r_shift     <= w_shift_nx;
      r_done      <= w_done_nx;
      r_busy      <= (w_state_nx != IDLE);
      r_frame_err <= (w_state_nx == ERR);
    end
  end

  // Output byte and level interrupt; a done in the same cycle beats rx_finish
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_data <= '0;
      r_irq     <= 1'b0;
    end else begin
      if (w_done_nx) r_rx_data <= r_shift;
      if (w_done_nx) begin
        r_irq <= 1'b1;
      end else if (rx_finish) begin
        r_irq <= 1'b0;
      end
    end
  end

  assign rx_data   = r_rx_data;
  assign done      = r_done;
  assign rx_busy   = r_busy;
  assign frame_err = r_frame_err;
  assign irq       = r_irq;

endmodule : uart_rx_core

`default_nettype wire

// File: tb/tb_uart_rx_core.sv
// ============================================================================
// Module      : tb_uart_rx_core
// Description : Self-checking bench for uart_rx_core (BAUD_DIV=16,
//               SYNC_STAGES=2) with a byte/latency scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_uart_rx_core;

  localparam int B   = 16;
  localparam int H   = B / 2;
  localparam int LAT = H + 9 * B + 2 + 1;

  logic       clk       = 1'b0;
  logic       rst_n     = 1'b0;
  logic       rx        = 1'b1;
  logic       rx_finish = 1'b0;
  logic [7:0] rx_data;
  logic       done, rx_busy, frame_err, irq;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int n_done = 0;
  int n_exp  = 0;
  int s;

  typedef struct {
    logic [7:0] data;
    int         start;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;

  uart_rx_core #(
    .BAUD_DIV    (B),
    .SYNC_STAGES (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .rx_finish (rx_finish),
    .rx_data   (rx_data),
    .done      (done),
    .rx_busy   (rx_busy),
    .frame_err (frame_err),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  // Count rising edges; read at negedges
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every done-high cycle must match the oldest pushed frame
  always @(negedge clk) begin
    if (rst_n && done) begin
      n_done++;
      if (q.size() == 0) begin
        chk("unexpected_done", q.size(), 1);
      end else begin
        mon_e = q.pop_front();
        chk("rx_data", rx_data, mon_e.data);
        chk("latency", cyc - mon_e.start, LAT);
        chk("irq_on_done", irq, 1);
      end
    end
  end

  // Drive one 8N1 frame starting at the current negedge
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input bit expect_done);
    logic [9:0] bits;
    bits = {stop_bit, b, 1'b0};
    if (expect_done) begin
      q.push_back('{data: b, start: cyc});
      n_exp++;
    end
    for (int i = 0; i < 10; i++) begin
      rx = bits[i];
      repeat (B) @(negedge clk);
    end
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_rx_data",   rx_data,   0);
    chk("rst_done",      done,      0);
    chk("rst_busy",      rx_busy,   0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_irq",       irq,       0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // 0xA5 frame
    s = cyc;
    fork
      send_frame(8'hA5, 1'b1, 1'b1);
      begin
        wait_cyc(s + 80);
        chk("busy_mid_frame", rx_busy, 1);
      end
    join
    rx = 1'b1;
    chk("a5_busy_after_stop", rx_busy, 0);
    chk("a5_rx_data", rx_data, 8'hA5);
    chk("a5_irq", irq, 1);
    chk("a5_done_count", n_done, n_exp);
    chk("a5_pending", q.size(), 0);
    repeat (4) @(negedge clk);

    // 5-cycle glitch while idle
    s = cyc;
    rx = 1'b0;
    wait_cyc(s + 4);
    chk("glitch_busy", rx_busy, 1);
    wait_cyc(s + 5);
    rx = 1'b1;
    wait_cyc(s + 10);
    chk("glitch_busy_before_mid", rx_busy, 1);
    wait_cyc(s + 11);
    chk("glitch_busy_after_mid", rx_busy, 0);
    chk("glitch_frame_err", frame_err, 0);
    chk("glitch_done_count", n_done, n_exp);
    repeat (4) @(negedge clk);

    // 0x3C with stop bit low -> framing error
    s = cyc;
    send_frame(8'h3C, 1'b0, 1'b0);
    rx = 1'b1;
    chk("ferr_set", frame_err, 1);
    chk("ferr_busy", rx_busy, 1);
    chk("ferr_rx_data_kept", rx_data, 8'hA5);
    chk("ferr_irq_kept", irq, 1);
    chk("ferr_done_count", n_done, n_exp);
    wait_cyc(s + 177);
    chk("ferr_hold", frame_err, 1);
    wait_cyc(s + 178);
    chk("ferr_clear", frame_err, 0);
    chk("ferr_busy_clear", rx_busy, 0);
    repeat (4) @(negedge clk);

    // Back-to-back 0x01 then 0xFF
    send_frame(8'h01, 1'b1, 1'b1);
    send_frame(8'hFF, 1'b1, 1'b1);
    rx = 1'b1;
    chk("b2b_rx_data", rx_data, 8'hFF);
    chk("b2b_irq", irq, 1);
    chk("b2b_done_count", n_done, n_exp);
    chk("b2b_pending", q.size(), 0);
    repeat (4) @(negedge clk);

    // irq acknowledge, idle acknowledge, and done-beats-finish
    send_frame(8'h55, 1'b1, 1'b1);
    rx = 1'b1;
    repeat (2) @(negedge clk);
    chk("irq_before_ack", irq, 1);
    rx_finish = 1'b1;
    @(negedge clk);
    rx_finish = 1'b0;
    chk("irq_cleared", irq, 0);
    rx_finish = 1'b1;
    @(negedge clk);
    rx_finish = 1'b0;
    chk("irq_idle_ack", irq, 0);
    s = cyc;
    fork
      send_frame(8'hC3, 1'b1, 1'b1);
      begin
        wait_cyc(s + LAT - 1);
        rx_finish = 1'b1;
        @(negedge clk);
        rx_finish = 1'b0;
      end
    join
    rx = 1'b1;
    chk("irq_done_wins", irq, 1);
    chk("c3_rx_data", rx_data, 8'hC3);
    repeat (4) @(negedge clk);

    // Asynchronous reset in the middle of 0x77's data bits
    rx = 1'b0;
    repeat (B) @(negedge clk);
    rx = 1'b1;
    repeat (2 * B + H) @(negedge clk);
    chk("mid_data_busy", rx_busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_rx_data",   rx_data,   0);
    chk("arst_busy",      rx_busy,   0);
    chk("arst_irq",       irq,       0);
    chk("arst_frame_err", frame_err, 0);
    chk("arst_done",      done,      0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    send_frame(8'h12, 1'b1, 1'b1);
    rx = 1'b1;
    chk("post_rst_rx_data", rx_data, 8'h12);
    chk("post_rst_irq", irq, 1);
    chk("final_done_count", n_done, n_exp);
    chk("final_pending", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_uart_rx_core

`default_nettype wire

// File: doc/uart_rx_core.md
Name: uart_rx_core

Overview:
- UART receive engine directly upstream of the UART controller.
- Deserialises the asynchronous rx pin (8N1, LSB first) into bytes, signalling each one with a single-cycle done pulse.
- Reports line busy, framing error and a level interrupt; the interrupt is held until the controller acknowledges with rx_finish.
- Feeds the controller's i_rx, done, i_rx_busy, i_frame_err and i_irq inputs.

Parameters:
- BAUD_DIV, 434, clk cycles per bit (50 MHz / 115200); legal range 8..65535.
- SYNC_STAGES, 2, flip-flops in the rx-pin synchroniser; legal range 2..3.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- rx  in  1  serial input pin; idles high
- rx_finish  in  1  controller acknowledge pulse; clears irq
- rx_data  out  8  last received byte; stable from done until the next done
- done  out  1  one-cycle pulse, byte valid
- rx_busy  out  1  high whenever state != IDLE
- frame_err  out  1  high while state == ERR
- irq  out  1  level interrupt; set by done, cleared by rx_finish

Behaviour:
- Reset (asynchronous, active-low):
  - Outputs: rx_data=0, done=0, rx_busy=0, frame_err=0, irq=0.
  - Internal: state=IDLE, synchroniser flops=1, counters=0.
- rx passes through SYNC_STAGES flops; the FSM sees only the synchronised value rxs.
- Counters:
  - baud_cnt is 16 bits and counts 0..BAUD_DIV-1.
  - bit_idx is 3 bits.
- FSM transitions:
  - IDLE: a 1->0 transition on rxs goes to START with baud_cnt=0.
  - START: when baud_cnt reaches BAUD_DIV/2-1 (mid start bit), sample rxs.
    - rxs=0: go to DATA with baud_cnt=0 and bit_idx=0.
    - rxs=1: glitch; return to IDLE with no done and no error.
  - DATA: every BAUD_DIV cycles, sample rxs into shift[bit_idx] (LSB first).
    - After bit_idx=7, go to STOP.
  - STOP: after BAUD_DIV cycles, sample rxs.
    - rxs=1: rx_data<=shift, done=1 for exactly one cycle, irq<=1, go to IDLE.
    - rxs=0: go to ERR; rx_data is unchanged and done is not pulsed.
  - ERR: frame_err=1 and rx_busy=1.
    - Stay until rxs has been continuously 1 for BAUD_DIV cycles; any 0 restarts that count.
    - Then go to IDLE; frame_err drops in the same cycle.
- Latency: done rises BAUD_DIV/2 + 9*BAUD_DIV + SYNC_STAGES + 1 cycles after the falling edge of the start bit on the pin.
- irq rules:
  - Set on a done cycle.
  - Cleared on a rx_finish cycle.
  - If rx_finish and done occur in the same cycle, done wins and irq stays 1.
- Overrun: a new byte overwrites rx_data even if irq is still set; overrun detection belongs to the controller.
- Back-to-back frames: a start edge is accepted in the cycle after the return to IDLE, with no dead time required.
- rx_finish while IDLE with irq=0 has no effect.
- rx_busy and frame_err are registered outputs, not decoded combinationally.

Optional Feature:
- Macro RX_MAJORITY_VOTE_EN.
- Defined:
  - Every sample point (start, data, stop) takes rxs at mid-bit-1, mid-bit and mid-bit+1.
  - The majority of the three samples is used.
  - Latency increases by 1 cycle.
- Undefined: a single sample at the mid-bit point.

Decomposition:
- Package uart_pkg holds:
  - the state enum: IDLE, START, DATA, STOP, ERR (3-bit);
  - UART_DATA_BITS=8;
  - the default BAUD_DIV constant.
- One sub-module, uart_rx_sync: the parameterised SYNC_STAGES synchroniser with reset value 1, outputting rxs.
- All remaining logic (FSM, counters, shift register, irq) stays in uart_rx_core.

Test Plan (all with BAUD_DIV=16, SYNC_STAGES=2):
- Send 0xA5 as 8N1 at 16 clk/bit -> one done pulse, rx_data=0xA5, irq=1; rx_busy low after the stop sample.
- Pulse rx low for 5 cycles while idle -> return to IDLE at mid-start, no done, frame_err=0, rx_busy high for about 10 cycles.
- Send 0x3C with the stop bit held 0, then idle high -> frame_err=1 until 16 consecutive high cycles, rx_data unchanged, no done, irq unchanged.
- Send 0x01 and 0xFF back-to-back with no idle gap -> two done pulses, rx_data=0x01 then 0xFF, irq remains 1.
- Receive 0x55 -> irq=1; pulse rx_finish -> irq=0 next cycle; force rx_finish coincident with the next done -> irq stays 1.
- Assert rst_n=0 mid-DATA of 0x77 -> all outputs 0 immediately; after release, the next frame 0x12 is received correctly.
